water_flow_monitor: RTL and testbench

- Supervises fill and drain progress for the main washing-machine control FSM.
- The FSM drives water_flow_mode and water_flow_reset, and consumes water_flow_error, which moves it into PAUSE.
- Over fixed observation windows the block compares the sampled water level against a baseline. It flags a fault when a fill or drain stalls for STRIKE_LIMIT consecutive windows.

---
 rtl/washer_pkg.sv | 47 ++++
 rtl/flow_window_tick.sv | 48 ++++
 rtl/water_flow_monitor.sv | 159 +++++++++++++++
 tb/tb_water_flow_monitor.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/washer_pkg.sv
// Shared definitions for the washing-machine control slice.
//
// Contents:
//   FLOW_MODE_FILL / FLOW_MODE_DRAIN : encoding of water_flow_mode
//   LEVEL_W                          : width of the water level sensor
//   mon_state_e                      : water flow monitor state encoding
//   window_good()                    : decides whether one observation window
//                                      showed enough progress
package washer_pkg;

  localparam logic FLOW_MODE_FILL  = 1'b1;
  localparam logic FLOW_MODE_DRAIN = 1'b0;

  localparam int LEVEL_W = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MONITOR = 2'd2,
    FAULT   = 2'd3
  } mon_state_e;

  // A fill window is good if the level rose by at least min_delta or the
  // tank is already full; a drain window is good if the level fell by at
  // least min_delta or the tank is empty. Noise in the wrong direction
  // therefore counts as a bad window.
  function automatic logic window_good(
    input logic                      mode,
    input logic signed [LEVEL_W:0]   delta,
    input logic        [LEVEL_W-1:0] level,
    input int                        min_delta,
    input int                        level_full
  );
    int d;
    int lv;
    logic good;
    d  = int'(delta);
    lv = int'(level);
    case (mode)
      FLOW_MODE_FILL:  good = (d >= min_delta) || (lv >= level_full);
      FLOW_MODE_DRAIN: good = (-d >= min_delta) || (lv == 0);
      default:         good = 1'b0;
    endcase
    return good;
  endfunction

endpackage

// File: rtl/flow_window_tick.sv
// Observation window counter for the water flow monitor.
//
// Counts 0..WINDOW_CYCLES-1 while enabled and wraps straight back to 0, so
// windows run back to back. tick_o is high for the single cycle on which the
// count equals WINDOW_CYCLES-1 (the evaluation cycle).
//
// Ports:
//   clk_i    : clock
//   rst_i    : synchronous active-high reset
//   clear_i  : synchronous clear of the count, wins over en_i
//   en_i     : count enable
//   tick_o   : one-cycle window end marker
module flow_window_tick #(
  parameter int WINDOW_CYCLES = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int            CW   = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WINDOW_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/water_flow_monitor.sv
// Water flow monitor: supervises fill and drain progress for the main
// washer FSM. Every WINDOW_CYCLES cycles the sampled level is compared with
// the level at the start of the window; STRIKE_LIMIT consecutive windows
// without enough progress latch a sticky fault.
//
// Ports:
//   clk                : system clock
//   reset              : synchronous active-high reset
//   water_flow_reset   : high holds the monitor idle and cleared
//   water_flow_mode    : 1 = filling, 0 = draining (ignored while cleared)
//   water_level_sensor : current water level
//   water_flow_error   : sticky flow/drain fault
//   flow_delta         : signed level change of the last completed window
//   monitor_active     : high while in ARM or MONITOR
//
// All outputs come straight from flops.
module water_flow_monitor
  import washer_pkg::*;
#(
  parameter int WINDOW_CYCLES = 1000,
  parameter int MIN_DELTA     = 2,
  parameter int STRIKE_LIMIT  = 3,
  parameter int LEVEL_FULL    = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               water_flow_reset,
  input  logic               water_flow_mode,
  input  logic [LEVEL_W-1:0] water_level_sensor,
  output logic               water_flow_error,
  output logic [LEVEL_W:0]   flow_delta,
  output logic               monitor_active
);

  localparam int            SW          = (STRIKE_LIMIT > 1) ? $clog2(STRIKE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] STRIKE_MAX  = SW'(STRIKE_LIMIT);
  localparam logic [SW-1:0] STRIKE_LAST = SW'(STRIKE_LIMIT - 1);

  mon_state_e state_q, state_d;

  logic [LEVEL_W-1:0] baseline_q, baseline_d;
  logic               mode_q, mode_d;
  logic [SW-1:0]      strikes_q, strikes_d;
  logic [LEVEL_W:0]   delta_q, delta_d;
  logic               err_q, err_d;
  logic               active_q, active_d;

  logic                    clear;
  logic                    mode_chg;
  logic                    tick;
  logic signed [LEVEL_W:0] delta_w;
  logic                    good;
  logic                    strike_hit;

  assign clear    = reset || water_flow_reset;
  assign mode_chg = (state_q == MONITOR) && (water_flow_mode != mode_q);

  // The counter is held at 0 outside MONITOR and on a mode change, so a
  // mode change on the evaluation cycle discards that window.
  flow_window_tick #(
    .WINDOW_CYCLES(WINDOW_CYCLES)
  ) u_tick (
    .clk_i  (clk),
    .rst_i  (clear),
    .clear_i(state_q != MONITOR || mode_chg),
    .en_i   (state_q == MONITOR),
    .tick_o (tick)
  );

  // Both operands zero-extended to 11 bits: the difference spans +-1023
  // and can never wrap.
  assign delta_w    = $signed({1'b0, water_level_sensor}) - $signed({1'b0, baseline_q});
  assign good       = window_good(mode_q, delta_w, water_level_sensor, MIN_DELTA, LEVEL_FULL);
  assign strike_hit = tick && !good && (strikes_q == STRIKE_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = ARM;
      ARM:     state_d = MONITOR;
      MONITOR: begin
        if (mode_chg) begin
          state_d = ARM;
        end else if (strike_hit) begin
          state_d = FAULT;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: registered decode of the upcoming state
  always_comb begin
    active_d = (state_d == ARM) || (state_d == MONITOR);
    err_d    = err_q || (state_d == FAULT);
  end

  // Window datapath: baseline, latched mode, strikes and last delta
  always_comb begin
    baseline_d = baseline_q;
    mode_d     = mode_q;
    strikes_d  = strikes_q;
    delta_d    = delta_q;
    unique case (state_q)
      ARM: begin
        baseline_d = water_level_sensor;
        mode_d     = water_flow_mode;
      end
      MONITOR: begin
        if (mode_chg) begin
          strikes_d = '0;
        end else if (tick) begin
          delta_d    = delta_w;
          baseline_d = water_level_sensor;
          if (good) begin
            strikes_d = '0;
          end else begin
            strikes_d = (strikes_q == STRIKE_MAX) ? STRIKE_MAX : strikes_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      baseline_q <= '0;
      mode_q     <= 1'b0;
      strikes_q  <= '0;
      delta_q    <= '0;
      err_q      <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      baseline_q <= baseline_d;
      mode_q     <= mode_d;
      strikes_q  <= strikes_d;
      delta_q    <= delta_d;
      err_q      <= err_d;
      active_q   <= active_d;
    end
  end

  assign water_flow_error = err_q;
  assign flow_delta       = delta_q;
  assign monitor_active   = active_q;

endmodule

// File: tb/tb_water_flow_monitor.sv
// Directed bench for water_flow_monitor with WINDOW_CYCLES=8, MIN_DELTA=2,
// STRIKE_LIMIT=3, LEVEL_FULL=1000.
//
// Timing reference: cyc counts rising edges. If water_flow_reset is lowered
// at the negedge of cycle c, edge c+1 is the first one that sees it low
// (IDLE->ARM), edge c+2 enters MONITOR with the baseline, and window k is
// evaluated on edge c+2+8k. A three-strike fault therefore shows on edge
// c+26, 25 cycles after the edge that first sampled the release.
module tb_water_flow_monitor;

  logic        clk;
  logic        reset;
  logic        water_flow_reset;
  logic        water_flow_mode;
  logic [9:0]  water_level_sensor;
  logic        water_flow_error;
  logic [10:0] flow_delta;
  logic        monitor_active;

  water_flow_monitor #(
    .WINDOW_CYCLES(8),
    .MIN_DELTA    (2),
    .STRIKE_LIMIT (3),
    .LEVEL_FULL   (1000)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .water_flow_reset  (water_flow_reset),
    .water_flow_mode   (water_flow_mode),
    .water_level_sensor(water_level_sensor),
    .water_flow_error  (water_flow_error),
    .flow_delta        (flow_delta),
    .monitor_active    (monitor_active)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks still queued", exp_q.size());
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // entry: {scenario[3:0], cycle[15:0], error, active, delta[10:0]}
  logic [32:0] exp_q[$];
  logic [32:0] item;
  int          cyc    = 0;
  int          n_vec  = 0;
  int          n_fail = 0;
  int          sc     = 0;
  string       sc_name [0:10];

  task automatic expect_at(input int at, input logic e, input logic a, input logic [10:0] d);
    logic [3:0]  id;
    logic [15:0] at16;
    id   = 4'(sc);
    at16 = 16'(at);
    exp_q.push_back({id, at16, e, a, d});
  endtask

  // Monitor: samples 1 time unit after each rising edge and retires every
  // expectation that belongs to this cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      while (exp_q.size() > 0 && int'(exp_q[0][28:13]) <= cyc) begin
        item = exp_q.pop_front();
        n_vec++;
        if (int'(item[28:13]) != cyc) begin
          n_fail++;
          $display("FAIL %s: check for cycle %0d never sampled (now %0d)",
                   sc_name[item[32:29]], int'(item[28:13]), cyc);
        end else if ({water_flow_error, monitor_active, flow_delta} !== item[12:0]) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: err/active/delta got %b/%b/%h want %b/%b/%h",
                   sc_name[item[32:29]], cyc, water_flow_error, monitor_active,
                   flow_delta, item[12], item[11], item[10:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; holds the monitor cleared for two cycles.
  task automatic clear_block();
    water_flow_reset = 1'b1;
    expect_at(cyc + 1, 1'b0, 1'b0, 11'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic start(input logic m, input logic [9:0] lv, output int c);
    @(negedge clk);
    water_flow_mode    = m;
    water_level_sensor = lv;
    water_flow_reset   = 1'b0;
    c = cyc;
    expect_at(c + 1, 1'b0, 1'b1, 11'd0);
  endtask

  // kind 0: hold level; kind 1: 100 + (n-c)/2; kind 2: p0 + p1 per window
  task automatic run_cycles(input int c, input int upto, input int kind,
                            input int p0, input int p1);
    int n;
    while (cyc < upto) begin
      @(negedge clk);
      n = cyc;
      case (kind)
        1: water_level_sensor = 10'(100 + (n - c) / 2);
        2: water_level_sensor = 10'(p0 + p1 * ((n + 1 - c - 2) / 8));
        default: ;
      endcase
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    sc_name[0]  = "reset";
    sc_name[1]  = "normal_fill";
    sc_name[2]  = "stalled_fill";
    sc_name[3]  = "blocked_drain";
    sc_name[4]  = "empty_drain";
    sc_name[5]  = "drain_min_delta";
    sc_name[6]  = "recovery";
    sc_name[7]  = "mode_toggle";
    sc_name[8]  = "clear_vs_fault";
    sc_name[9]  = "noise_then_reset";
    sc_name[10] = "full_level";

    reset              = 1'b1;
    water_flow_reset   = 1'b1;
    water_flow_mode    = 1'b0;
    water_level_sensor = 10'd0;

    sc = 0;
    @(negedge clk);
    expect_at(cyc + 1, 1'b0, 1'b0, 11'd0);
    expect_at(cyc + 2, 1'b0, 1'b0, 11'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_block();

    // +1 every 2 cycles: +4 per window, never faults
    sc = 1;
    start(1'b1, 10'd100, c);
    for (int k = 1; k <= 10; k++) expect_at(c + 2 + 8 * k, 1'b0, 1'b1, 11'd4);
    run_cycles(c, c + 84, 1, 0, 0);
    clear_block();

    // level stuck at 50 while filling: fault on edge c+26, held until clear
    sc = 2;
    start(1'b1, 10'd50, c);
    expect_at(c + 10, 1'b0, 1'b1, 11'd0);
    expect_at(c + 25, 1'b0, 1'b1, 11'd0);
    expect_at(c + 26, 1'b1, 1'b0, 11'd0);
    expect_at(c + 31, 1'b1, 1'b0, 11'd0);
    run_cycles(c, c + 31, 0, 0, 0);
    clear_block();

    sc = 3;
    start(1'b0, 10'd300, c);
    expect_at(c + 25, 1'b0, 1'b1, 11'd0);
    expect_at(c + 26, 1'b1, 1'b0, 11'd0);
    run_cycles(c, c + 28, 0, 0, 0);
    clear_block();

    // empty tank while draining is always good
    sc = 4;
    start(1'b0, 10'd0, c);
    for (int k = 1; k <= 5; k++) expect_at(c + 2 + 8 * k, 1'b0, 1'b1, 11'd0);
    run_cycles(c, c + 44, 0, 0, 0);
    clear_block();

    // exactly -MIN_DELTA per window while draining: good, delta = -2
    sc = 5;
    start(1'b0, 10'd600, c);
    for (int k = 1; k <= 4; k++) expect_at(c + 2 + 8 * k, 1'b0, 1'b1, 11'h7FE);
    run_cycles(c, c + 36, 2, 600, -2);
    clear_block();

    // bad, bad, good(+5), bad, bad -> no fault; a third bad window then faults
    sc = 6;
    start(1'b1, 10'd200, c);
    expect_at(c + 10, 1'b0, 1'b1, 11'd0);
    expect_at(c + 18, 1'b0, 1'b1, 11'd0);
    expect_at(c + 26, 1'b0, 1'b1, 11'd5);
    expect_at(c + 34, 1'b0, 1'b1, 11'd0);
    expect_at(c + 42, 1'b0, 1'b1, 11'd0);
    expect_at(c + 49, 1'b0, 1'b1, 11'd0);
    expect_at(c + 50, 1'b1, 1'b0, 11'd0);
    run_cycles(c, c + 20, 0, 0, 0);
    water_level_sensor = 10'd205;
    run_cycles(c, c + 52, 0, 0, 0);
    clear_block();

    // two bad fill windows, then switch to drain mid-window: re-arm on edge
    // c+22, fresh drain windows end on c+31/39/47
    sc = 7;
    start(1'b1, 10'd400, c);
    expect_at(c + 18, 1'b0, 1'b1, 11'd0);
    expect_at(c + 22, 1'b0, 1'b1, 11'd0);
    expect_at(c + 26, 1'b0, 1'b1, 11'd0);
    expect_at(c + 46, 1'b0, 1'b1, 11'd0);
    expect_at(c + 47, 1'b1, 1'b0, 11'd0);
    run_cycles(c, c + 21, 0, 0, 0);
    water_flow_mode = 1'b0;
    run_cycles(c, c + 49, 0, 0, 0);
    clear_block();

    // clear arrives on the very edge that would raise the fault
    sc = 8;
    start(1'b1, 10'd50, c);
    expect_at(c + 25, 1'b0, 1'b1, 11'd0);
    expect_at(c + 26, 1'b0, 1'b0, 11'd0);
    expect_at(c + 27, 1'b0, 1'b0, 11'd0);
    run_cycles(c, c + 25, 0, 0, 0);
    water_flow_reset = 1'b1;
    repeat (3) @(negedge clk);

    // level creeping down while filling (-1 per window), then reset in FAULT
    sc = 9;
    start(1'b1, 10'd500, c);
    expect_at(c + 10, 1'b0, 1'b1, 11'h7FF);
    expect_at(c + 18, 1'b0, 1'b1, 11'h7FF);
    expect_at(c + 26, 1'b1, 1'b0, 11'h7FF);
    expect_at(c + 29, 1'b0, 1'b0, 11'd0);
    run_cycles(c, c + 28, 2, 500, -1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_block();

    // full tank while filling is always good
    sc = 10;
    start(1'b1, 10'd1000, c);
    for (int k = 1; k <= 4; k++) expect_at(c + 2 + 8 * k, 1'b0, 1'b1, 11'd0);
    expect_at(c + 35, 1'b0, 1'b1, 11'd0);
    run_cycles(c, c + 36, 0, 0, 0);
    clear_block();

    repeat (4) @(negedge clk);
    while (exp_q.size() > 0) begin
      item = exp_q.pop_front();
      n_vec++;
      n_fail++;
      $display("FAIL %s: check for cycle %0d left unchecked",
               sc_name[item[32:29]], int'(item[28:13]));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
